// File: rtl/pixl_seq_pkg.sv
// pixl_seq_pkg: shared constants for the pixel-to-symbol sequencer.
//   - PIXL_CNT_W   : default width of the cycle and run counters
//   - pixl_state_t : controller state encoding (StIdle, StS0, StS1, StFin)
package pixl_seq_pkg;

    localparam int unsigned PIXL_CNT_W = 32;

    typedef logic [1:0] pixl_state_t;

    localparam pixl_state_t StIdle = 2'd0;
    localparam pixl_state_t StS0   = 2'd1;
    localparam pixl_state_t StS1   = 2'd2;
    localparam pixl_state_t StFin  = 2'd3;

endpackage

// File: rtl/pixl_sat_cnt.sv
// pixl_sat_cnt: saturating up-counter.
//   clk  : clock
//   rst  : synchronous active-high reset, forces the count to zero
//   clr  : synchronous clear (takes priority over en)
//   en   : count enable; the count stops at all-ones and never wraps
//   q    : current count
//   sat  : high while the count sits at all-ones
module pixl_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] CntMax = '1;

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q   = cnt_q;
    assign sat = (cnt_q == CntMax);

endmodule

// File: rtl/pixl_seq_ctrl.sv
// pixl_seq_ctrl: sequences the two pipelined loop engines (stage 0 pixel unpack, then
// stage 1 symbol mapping) behind an ap_ctrl_hs host handshake and profiles each stage.
//   ap_clk, ap_rst             : clock, synchronous active-high reset
//   ap_start                   : host start request (level, sampled only in idle)
//   ap_done, ap_ready          : one-cycle pulse at the end of each run
//   ap_idle                    : high while idle
//   s0_start/s0_ready/s0_done  : stage 0 engine handshake
//   s1_start/s1_ready/s1_done  : stage 1 engine handshake
//   cyc_s0, cyc_s1             : cycles spent in each stage on the last or current run
//   run_cnt                    : completed runs since reset
//   err                        : sticky; spurious done or any counter saturating
// All outputs come from flops or from decoding the registered state.
module pixl_seq_ctrl
    import pixl_seq_pkg::*;
#(
    parameter int unsigned CNT_W = PIXL_CNT_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             s0_start,
    input  logic             s0_ready,
    input  logic             s0_done,
    output logic             s1_start,
    input  logic             s1_ready,
    input  logic             s1_done,
    output logic [CNT_W-1:0] cyc_s0,
    output logic [CNT_W-1:0] cyc_s1,
    output logic [CNT_W-1:0] run_cnt,
    output logic             err
);

    pixl_state_t state_d, state_q;
    logic        s0_start_d, s0_start_q;
    logic        s1_start_d, s1_start_q;
    logic        err_d, err_q;

    logic run_begin;
    logic s0_leave;
    logic sat_s0, sat_s1, sat_run;

    assign run_begin = (state_q == StIdle) && ap_start;
    assign s0_leave  = (state_q == StS0) && s0_done;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ap_start) state_d = StS0;
            StS0:    if (s0_done)  state_d = StS1;
            StS1:    if (s1_done)  state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A start request is withdrawn once the engine accepts it; leaving the stage also
    // withdraws it, since a done implies the engine ran.
    always_comb begin
        s0_start_d = s0_start_q;
        if (run_begin) begin
            s0_start_d = 1'b1;
        end else if (s0_ready || (state_q != StS0) || s0_done) begin
            s0_start_d = 1'b0;
        end
    end

    always_comb begin
        s1_start_d = s1_start_q;
        if (s0_leave) begin
            s1_start_d = 1'b1;
        end else if (s1_ready || (state_q != StS1) || s1_done) begin
            s1_start_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (s0_done && (state_q != StS0)) err_d = 1'b1;
        if (s1_done && (state_q != StS1)) err_d = 1'b1;
        if (sat_s0 || sat_s1 || sat_run)  err_d = 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= StIdle;
            s0_start_q <= 1'b0;
            s1_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s0_start_q <= s0_start_d;
            s1_start_q <= s1_start_d;
            err_q      <= err_d;
        end
    end

    // Both stage counters restart together at the beginning of a run.
    pixl_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_s0 (
        .clk (ap_clk),
        .rst (ap_rst),
        .clr (run_begin),
        .en  (state_q == StS0),
        .q   (cyc_s0),
        .sat (sat_s0)
    );

    pixl_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_s1 (
        .clk (ap_clk),
        .rst (ap_rst),
        .clr (run_begin),
        .en  (state_q == StS1),
        .q   (cyc_s1),
        .sat (sat_s1)
    );

    pixl_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_run (
        .clk (ap_clk),
        .rst (ap_rst),
        .clr (1'b0),
        .en  (state_q == StFin),
        .q   (run_cnt),
        .sat (sat_run)
    );

    assign ap_idle  = (state_q == StIdle);
    assign ap_done  = (state_q == StFin);
    assign ap_ready = (state_q == StFin);
    assign s0_start = s0_start_q;
    assign s1_start = s1_start_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pixl_seq_ctrl.sv
// Bench for pixl_seq_ctrl. Cycle k of a run is counted from the cycle in which ap_start is
// first seen in idle; expected handshake waveforms come from the run's timing rules.
module tb_pixl_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (32-bit counters)
    logic        rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        s0_ready = 1'b0, s0_done = 1'b0, s1_ready = 1'b0, s1_done = 1'b0;
    logic        ap_done, ap_ready, ap_idle, s0_start, s1_start, err;
    logic [31:0] cyc_s0, cyc_s1, run_cnt;

    // Narrow instance (4-bit counters) for saturation
    logic        rst4 = 1'b1;
    logic        start4 = 1'b0;
    logic        s0r4 = 1'b0, s0d4 = 1'b0, s1r4 = 1'b0, s1d4 = 1'b0;
    logic        done4, ready4, idle4, s0st4, s1st4, err4;
    logic [3:0]  cyc_s0_4, cyc_s1_4, run_cnt_4;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_runs = 0;

    pixl_seq_ctrl #(.CNT_W(32)) dut (
        .ap_clk   (clk),
        .ap_rst   (rst),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .s0_start (s0_start),
        .s0_ready (s0_ready),
        .s0_done  (s0_done),
        .s1_start (s1_start),
        .s1_ready (s1_ready),
        .s1_done  (s1_done),
        .cyc_s0   (cyc_s0),
        .cyc_s1   (cyc_s1),
        .run_cnt  (run_cnt),
        .err      (err)
    );

    pixl_seq_ctrl #(.CNT_W(4)) dut4 (
        .ap_clk   (clk),
        .ap_rst   (rst4),
        .ap_start (start4),
        .ap_done  (done4),
        .ap_ready (ready4),
        .ap_idle  (idle4),
        .s0_start (s0st4),
        .s0_ready (s0r4),
        .s0_done  (s0d4),
        .s1_start (s1st4),
        .s1_ready (s1r4),
        .s1_done  (s1d4),
        .cyc_s0   (cyc_s0_4),
        .cyc_s1   (cyc_s1_4),
        .run_cnt  (run_cnt_4),
        .err      (err4)
    );

    // Advance one cycle; sampling and driving both happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ap_start = 1'b0;
        s0_ready = 1'b0; s0_done = 1'b0; s1_ready = 1'b0; s1_done = 1'b0;
        tick();
        rst = 1'b0;
        exp_runs = 0;
    endtask

    // One run: s0_done at cycle d, s0_ready r0 cycles after s0_start rises,
    // s1_done lat1 cycles after s0_done, s1_ready r1 cycles after s1_start rises.
    task automatic do_run(input int d, input int r0, input int lat1, input int r1,
                          input bit hold, input string tag);
        int e;
        logic [4:0] exp_v;
        logic [4:0] got_v;
        e = d + lat1;
        for (int k = 0; k <= e + 1; k++) begin
            exp_v = {k == 0, (k >= 1) && (k <= 1 + r0), (k >= d + 1) && (k <= d + 1 + r1),
                     k == e + 1, k == e + 1};
            got_v = {ap_idle, s0_start, s1_start, ap_done, ap_ready};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s_hs k=%0d: idle/s0st/s1st/done/rdy got %b want %b",
                         tag, k, got_v, exp_v);
            end
            if (k == e + 1) begin
                n_cmp++;
                if (cyc_s0 !== 32'(d) || cyc_s1 !== 32'(lat1) || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_cnt: cyc_s0=%0d cyc_s1=%0d err=%b want %0d %0d 0",
                             tag, cyc_s0, cyc_s1, err, d, lat1);
                end
            end
            ap_start = (k == 0) || hold;
            s0_ready = (k == 1 + r0);
            s0_done  = (k == d);
            s1_ready = (k == d + 1 + r1);
            s1_done  = (k == e);
            tick();
        end
        exp_runs++;
        n_cmp++;
        if (run_cnt !== 32'(exp_runs) || ap_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_end: run_cnt=%0d idle=%b want %0d 1", tag, run_cnt, ap_idle,
                     exp_runs);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ap_idle, ap_done, ap_ready, s0_start, s1_start, err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 100000",
                     {ap_idle, ap_done, ap_ready, s0_start, s1_start, err});
        end
        n_cmp++;
        if (cyc_s0 !== 32'd0 || cyc_s1 !== 32'd0 || run_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", cyc_s0, cyc_s1, run_cnt);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        do_run(30, 0, 80, 0, 1'b0, "nominal");
    endtask

    task automatic test_random();
        int d, r0, lat1, r1, gap;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            r0   = int'($urandom_range(0, 3));
            d    = r0 + 1 + int'($urandom_range(0, 10));
            r1   = int'($urandom_range(0, 3));
            lat1 = r1 + 1 + int'($urandom_range(0, 10));
            do_run(d, r0, lat1, r1, 1'b0, "random");
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                tick();
                n_cmp++;
                if (ap_idle !== 1'b1 || cyc_s0 !== 32'(d) || cyc_s1 !== 32'(lat1)) begin
                    n_fail++;
                    $display("FAIL random_hold: idle=%b cyc_s0=%0d cyc_s1=%0d want 1 %0d %0d",
                             ap_idle, cyc_s0, cyc_s1, d, lat1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 3; n++) do_run(5, 0, 7, 0, 1'b1, "b2b");
        ap_start = 1'b0;
        n_cmp++;
        if (run_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL b2b_runs: run_cnt=%0d want 3", run_cnt);
        end
    endtask

    task automatic test_late_ready();
        do_reset();
        do_run(12, 4, 3, 0, 1'b0, "late_ready");
    endtask

    task automatic test_same_cycle();
        do_reset();
        do_run(6, 1, 1, 0, 1'b0, "same_cycle");
    endtask

    task automatic test_spurious_reset();
        do_reset();
        s0_done = 1'b1;
        tick();
        s0_done = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || ap_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_idle: err=%b idle=%b want 1 1", err, ap_idle);
        end
        do_reset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        s1_done = 1'b1;
        tick();
        s1_done = 1'b0;
        n_cmp++;
        if ({err, ap_idle, ap_done, s0_start, s1_start} !== 5'b10010 || cyc_s0 !== 32'd2) begin
            n_fail++;
            $display("FAIL spur_s0: err/idle/done/s0st/s1st=%b cyc_s0=%0d want 10010 2",
                     {err, ap_idle, ap_done, s0_start, s1_start}, cyc_s0);
        end
        tick();
        n_cmp++;
        if ({err, ap_idle, ap_done, s0_start, s1_start} !== 5'b10010 || cyc_s0 !== 32'd3) begin
            n_fail++;
            $display("FAIL spur_stay: err/idle/done/s0st/s1st=%b cyc_s0=%0d want 10010 3",
                     {err, ap_idle, ap_done, s0_start, s1_start}, cyc_s0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_runs = 0;
        n_cmp++;
        if ({ap_idle, s0_start, s1_start, ap_done, err} !== 5'b10000 ||
            cyc_s0 !== 32'd0 || cyc_s1 !== 32'd0 || run_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: flags=%b cnt=%0d/%0d/%0d want 10000 0/0/0",
                     {ap_idle, s0_start, s1_start, ap_done, err}, cyc_s0, cyc_s1, run_cnt);
        end
    endtask

    task automatic test_saturation();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        for (int k = 0; k <= 23; k++) begin
            if (k == 10) begin
                n_cmp++;
                if (err4 !== 1'b0 || cyc_s0_4 !== 4'd9) begin
                    n_fail++;
                    $display("FAIL sat_early: err=%b cyc_s0=%0d want 0 9", err4, cyc_s0_4);
                end
            end
            if (k == 22) begin
                n_cmp++;
                if (cyc_s0_4 !== 4'd15 || err4 !== 1'b1 || done4 !== 1'b1 ||
                    cyc_s1_4 !== 4'd1) begin
                    n_fail++;
                    $display("FAIL sat_cnt: cyc_s0=%0d err=%b done=%b cyc_s1=%0d want 15 1 1 1",
                             cyc_s0_4, err4, done4, cyc_s1_4);
                end
            end
            if (k == 23) begin
                n_cmp++;
                if (run_cnt_4 !== 4'd1 || idle4 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_end: run_cnt=%0d idle=%b want 1 1", run_cnt_4, idle4);
                end
            end
            start4 = (k == 0);
            s0r4   = (k == 1);
            s0d4   = (k == 20);
            s1r4   = (k == 21);
            s1d4   = (k == 21);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_random();
        test_back_to_back();
        test_late_ready();
        test_same_cycle();
        test_spurious_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
